// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file and scoreboard.
// master: decode + writeback side, slave: regfile_scoreboard.
interface regfile_scoreboard_if #(
   parameter int XLEN = 64
);
   logic [4:0]      ra1;
   logic [4:0]      ra2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            busy1;
   logic            busy2;
   logic            issue_valid;
   logic            issue_wen;
   logic [4:0]      issue_dst;
   logic            issue_full;
   logic            wb_valid;
   logic            wb_wen;
   logic [4:0]      wb_dst;
   logic [XLEN-1:0] wb_data;
   logic            flush;

   modport master (
      output ra1, ra2,
      output issue_valid, issue_wen, issue_dst,
      output wb_valid, wb_wen, wb_dst, wb_data,
      output flush,
      input  rd1, rd2, busy1, busy2, issue_full
   );

   modport slave (
      input  ra1, ra2,
      input  issue_valid, issue_wen, issue_dst,
      input  wb_valid, wb_wen, wb_dst, wb_data,
      input  flush,
      output rd1, rd2, busy1, busy2, issue_full
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters.
// Ports: clk, reset (async, active-low), bus (slave: reads, issue, writeback).
module regfile_scoreboard #(
   parameter int NREG  = 32,
   parameter int XLEN  = 64,
   parameter int CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  bus
);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] CZERO = '0;

   logic [XLEN-1:0]  regs [NREG];
   logic [CNT_W-1:0] cnt  [NREG];

   logic            wr;
   logic            hit1;
   logic            hit2;
   logic            hit_iss;
   logic            accept;
   logic [NREG-1:0] inc_oh;
   logic [NREG-1:0] dec_oh;

   // While reset is held every output is forced quiet, including bypass.
   assign wr = reset & bus.wb_valid & bus.wb_wen & (bus.wb_dst != 5'd0);

   assign hit1    = wr & (bus.wb_dst == bus.ra1);
   assign hit2    = wr & (bus.wb_dst == bus.ra2);
   assign hit_iss = wr & (bus.wb_dst == bus.issue_dst);

   always_comb begin
      bus.rd1 = '0;
      bus.busy1 = 1'b0;
      if (reset && bus.ra1 != 5'd0) begin
         bus.rd1 = hit1 ? bus.wb_data : regs[bus.ra1];
         // busy drops only when the retiring write is the last one pending
         bus.busy1 = cnt[bus.ra1] > {CZERO[CNT_W-1:1], hit1};
      end
   end

   always_comb begin
      bus.rd2 = '0;
      bus.busy2 = 1'b0;
      if (reset && bus.ra2 != 5'd0) begin
         bus.rd2 = hit2 ? bus.wb_data : regs[bus.ra2];
         bus.busy2 = cnt[bus.ra2] > {CZERO[CNT_W-1:1], hit2};
      end
   end

   // A same-cycle retire frees one slot, so a saturated counter can accept.
   assign bus.issue_full = reset & bus.issue_wen
                         & (bus.issue_dst != 5'd0)
                         & (cnt[bus.issue_dst] == CMAX)
                         & ~hit_iss;

   assign accept = bus.issue_valid & bus.issue_wen
                 & (bus.issue_dst != 5'd0)
                 & ~bus.issue_full & ~bus.flush;

   always_comb begin
      inc_oh = '0;
      dec_oh = '0;
      if (accept) inc_oh[bus.issue_dst] = 1'b1;
      if (wr)     dec_oh[bus.wb_dst]    = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            if (bus.flush) begin
               cnt[r] <= '0;
            end else if (inc_oh[r] && !dec_oh[r]) begin
               cnt[r] <= cnt[r] + 1'b1;
            end else if (dec_oh[r] && !inc_oh[r] && cnt[r] != CZERO) begin
               cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

   // Data commits regardless of flush or counter underflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr) begin
         regs[bus.wb_dst] <= bus.wb_data;
      end
   end
endmodule
